// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH
   } fetch_state_t;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush/count; async active-low reset.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             do_push, do_pop;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   // A pop frees the slot in the same cycle, so push-while-full is accepted with it.
   assign do_push   = push && (!full || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC issue, in-order PC queue, prefetch buffer, redirect flush.
// Optional FETCH_PERF_COUNT_EN adds RedirectCount/DropCount outputs.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                     CLK,
   input  logic                     RST,
   output logic                     IMemReq,
   output logic [DATA_WIDTH-1:0]    IMemAddr,
   input  logic                     IMemRValid,
   input  logic [DATA_WIDTH-1:0]    IMemRData,
   output logic                     InstrValid,
   input  logic                     InstrReady,
   output logic [DATA_WIDTH-1:0]    Instr,
   output logic [DATA_WIDTH-1:0]    InstrPC,
   input  logic                     Redirect,
   input  logic [DATA_WIDTH-1:0]    RedirectPC,
   output logic [$clog2(DEPTH):0]   Occupancy
`ifdef FETCH_PERF_COUNT_EN
   ,
   output logic [31:0]              RedirectCount,
   output logic [31:0]              DropCount
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t            state, state_nxt;
   logic [DATA_WIDTH-1:0]   fetch_pc, fetch_pc_nxt, redirect_pc, pcq_head;
   logic [CW-1:0]           drop, drop_nxt, pcq_count, dq_count;
   logic [CW:0]             credit_used;
   logic [2*DATA_WIDTH-1:0] dq_head;
   logic                    pcq_full, pcq_empty, dq_full, dq_empty;
   logic                    issue, accept, pop_head, pcq_pop;

   assign redirect_pc = RedirectPC & ~DATA_WIDTH'(INSTR_BYTES - 1);
   // Credit covers both in-flight requests and buffered words, so responses never overflow.
   assign credit_used = {1'b0, pcq_count} + {1'b0, dq_count};
   assign issue       = (state == RUN) && !Redirect && !pcq_full && (credit_used < (CW+1)'(DEPTH));
   assign accept      = IMemRValid && (state == RUN) && !Redirect;
   assign pcq_pop     = IMemRValid && (state == RUN);
   assign InstrValid  = !dq_empty && !Redirect;
   assign pop_head    = InstrValid && InstrReady;

   assign IMemReq          = issue;
   assign IMemAddr         = fetch_pc;
   assign {InstrPC, Instr} = dq_head;
   assign Occupancy        = dq_count;

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_pcq (
      .clk(CLK), .rst_n(RST), .push(issue), .push_data(fetch_pc), .pop(pcq_pop),
      .flush(Redirect), .head_data(pcq_head), .count(pcq_count), .full(pcq_full), .empty(pcq_empty)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*DATA_WIDTH)) u_dq (
      .clk(CLK), .rst_n(RST), .push(accept), .push_data({pcq_head, IMemRData}), .pop(pop_head),
      .flush(Redirect), .head_data(dq_head), .count(dq_count), .full(dq_full), .empty(dq_empty)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         drop     <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         drop     <= drop_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      drop_nxt     = drop;
      case (state)
         IDLE: begin
            state_nxt = RUN;
            if (Redirect) fetch_pc_nxt = redirect_pc;
         end
         RUN: begin
            if (Redirect) begin
               fetch_pc_nxt = redirect_pc;
               // The PC queue is flushed; in-flight responses are tracked by drop instead.
               drop_nxt     = pcq_count - CW'(IMemRValid);
               if (drop_nxt != '0) state_nxt = FLUSH;
            end else if (issue) begin
               fetch_pc_nxt = fetch_pc + DATA_WIDTH'(INSTR_BYTES);
            end
         end
         FLUSH: begin
            if (Redirect) fetch_pc_nxt = redirect_pc;
            if (IMemRValid) begin
               drop_nxt = drop - CW'(1);
               if (drop == CW'(1)) state_nxt = RUN;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef FETCH_PERF_COUNT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         RedirectCount <= '0;
         DropCount     <= '0;
      end else begin
         if (Redirect && (RedirectCount != '1)) RedirectCount <= RedirectCount + 32'd1;
         if (IMemRValid && !accept && (DropCount != '1)) DropCount <= DropCount + 32'd1;
      end
   end
`endif

   a_no_overflow: assert property (@(posedge CLK) disable iff (!RST)
      !(accept && dq_full && !pop_head));
   a_no_orphan: assert property (@(posedge CLK) disable iff (!RST)
      IMemRValid |-> ((state == FLUSH) ? (drop != '0) : !pcq_empty));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemRValid = 1'b0;
   logic [31:0] IMemRData = '0;
   logic        InstrValid;
   logic        InstrReady = 1'b0;
   logic [31:0] Instr, InstrPC;
   logic        Redirect = 1'b0;
   logic [31:0] RedirectPC = '0;
   logic [2:0]  Occupancy;
`ifdef FETCH_PERF_COUNT_EN
   logic [31:0] RedirectCount, DropCount;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned lat = 1;
   int unsigned cyc = 0;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } req_t;
   req_t pend[$];

   fetch_unit #(.DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .CLK(CLK), .RST(RST), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
      .IMemRValid(IMemRValid), .IMemRData(IMemRData), .InstrValid(InstrValid),
      .InstrReady(InstrReady), .Instr(Instr), .InstrPC(InstrPC), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .Occupancy(Occupancy)
`ifdef FETCH_PERF_COUNT_EN
      , .RedirectCount(RedirectCount), .DropCount(DropCount)
`endif
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Memory: request seen in cycle t answers in cycle t+lat, in order.
   always @(posedge CLK) begin
      if (!RST) begin
         pend.delete();
         #1;
         IMemRValid = 1'b0;
         IMemRData  = '0;
      end else begin
         if (IMemReq) pend.push_back('{IMemAddr, cyc + lat});
         cyc++;
         #1;
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            IMemRValid = 1'b1;
            IMemRData  = word_of(pend[0].addr);
            void'(pend.pop_front());
         end else begin
            IMemRValid = 1'b0;
            IMemRData  = '0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Returns at the sample point of the first cycle after release (IDLE).
   task automatic do_reset(input logic rdy, input int unsigned l);
      @(negedge CLK);
      RST = 1'b0; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0; lat = l;
      repeat (2) @(negedge CLK);
      InstrReady = rdy;
      RST = 1'b1;
      #1;
   endtask

   // Latency 3, no ready: redirect to 0x103 in the first cycle one word is buffered.
   task automatic flush_setup();
      bit found = 0;
      do_reset(1'b0, 3);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK); #1;
         if (Occupancy == 3'd1) begin found = 1; break; end
      end
      chk("flush_found", 32'(found), 32'd1);
      Redirect = 1'b1; RedirectPC = 32'h0000_0103;
      #1;
   endtask

   initial begin
      int unsigned n_req, n_got;
      logic [31:0] exp_addr, exp_pc;
      logic [31:0] wrap_exp [3];

      // Reset values
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_req", 32'(IMemReq), 32'd0);
      chk("rst_addr", IMemAddr, 32'h0);
      chk("rst_valid", 32'(InstrValid), 32'd0);
      chk("rst_instr", Instr, 32'h0);
      chk("rst_pc", InstrPC, 32'h0);
      chk("rst_occ", 32'(Occupancy), 32'd0);

      // Streaming, latency 1, ready always
      do_reset(1'b1, 1);
      chk("idle_req", 32'(IMemReq), 32'd0);
      exp_addr = 0; exp_pc = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK); #1;
         if (i == 0) chk("first_req", 32'(IMemReq), 32'd1);
         if (IMemReq) begin chk("stream_addr", IMemAddr, exp_addr); exp_addr += 4; end
         if (InstrValid) begin
            chk("stream_pc", InstrPC, exp_pc);
            chk("stream_instr", Instr, word_of(exp_pc));
            exp_pc += 4;
         end
         chk("stream_occ_le1", 32'(Occupancy <= 3'd1), 32'd1);
      end
      chk("stream_nreq", exp_addr, 32'h30);
      chk("stream_ndeliv", exp_pc, 32'h28);

      // Backpressure fills exactly DEPTH
      do_reset(1'b0, 1);
      n_req = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK); #1;
         if (IMemReq) begin chk("bp_addr", IMemAddr, 32'(n_req * 4)); n_req++; end
         if (InstrValid) begin
            chk("bp_hold_pc", InstrPC, 32'h0);
            chk("bp_hold_instr", Instr, word_of(32'h0));
         end
      end
      chk("bp_nreq", 32'(n_req), 32'd4);
      chk("bp_occ", 32'(Occupancy), 32'd4);
      chk("bp_valid", 32'(InstrValid), 32'd1);
      n_got = 0;
      for (int i = 0; i < 10 && n_got < 4; i++) begin
         @(negedge CLK); InstrReady = 1'b1; #1;
         if (InstrValid) begin
            chk("bp_rel_pc", InstrPC, 32'(n_got * 4));
            chk("bp_rel_instr", Instr, word_of(32'(n_got * 4)));
            n_got++;
         end
      end
      chk("bp_rel_n", 32'(n_got), 32'd4);

      // Redirect with in-flight responses -> FLUSH
      flush_setup();
      chk("fl_mask", 32'(InstrValid), 32'd0);
      chk("fl_req0", 32'(IMemReq), 32'd0);
      @(negedge CLK); Redirect = 1'b0; #1;
      chk("fl_occ", 32'(Occupancy), 32'd0);
      chk("fl_valid", 32'(InstrValid), 32'd0);
      chk("fl_req1", 32'(IMemReq), 32'd0);
      @(negedge CLK); #1;
      chk("fl_req2", 32'(IMemReq), 32'd0);
      @(negedge CLK); #1;
      chk("fl_restart", 32'(IMemReq), 32'd1);
      chk("fl_addr", IMemAddr, 32'h100);
`ifdef FETCH_PERF_COUNT_EN
      chk("fl_redir_cnt", RedirectCount, 32'd1);
      chk("fl_drop_cnt", DropCount, 32'd3);
`endif
      InstrReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK); #1;
         if (InstrValid) break;
      end
      chk("fl_got", 32'(InstrValid), 32'd1);
      chk("fl_pc", InstrPC, 32'h100);
      chk("fl_instr", Instr, word_of(32'h100));

      // Redirect coinciding with a transfer and a response
      do_reset(1'b1, 1);
      repeat (5) @(negedge CLK);
      Redirect = 1'b1; RedirectPC = 32'h0000_0200;
      #1;
      chk("rc_occ_pre", 32'(Occupancy), 32'd1);
      chk("rc_mask", 32'(InstrValid), 32'd0);
      @(negedge CLK); Redirect = 1'b0; #1;
      chk("rc_occ", 32'(Occupancy), 32'd0);
      chk("rc_req", 32'(IMemReq), 32'd1);
      chk("rc_addr", IMemAddr, 32'h200);
`ifdef FETCH_PERF_COUNT_EN
      chk("rc_redir_cnt", RedirectCount, 32'd1);
      chk("rc_drop_cnt", DropCount, 32'd1);
`endif
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK); #1;
         if (InstrValid) break;
      end
      chk("rc_pc", InstrPC, 32'h200);
      chk("rc_instr", Instr, word_of(32'h200));

      // PC wrap, unaligned redirect target
      do_reset(1'b1, 1);
      @(negedge CLK); Redirect = 1'b1; RedirectPC = 32'hFFFF_FFF9; #1;
      chk("wr_req_mask", 32'(IMemReq), 32'd0);
      wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
      n_req = 0; n_got = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK); Redirect = 1'b0; #1;
         if (IMemReq && n_req < 3) begin chk("wr_addr", IMemAddr, wrap_exp[n_req]); n_req++; end
         if (InstrValid && n_got < 3) begin chk("wr_pc", InstrPC, wrap_exp[n_got]); n_got++; end
      end
      chk("wr_nreq", 32'(n_req), 32'd3);

      // Async reset in FLUSH with drop=2
      flush_setup();
      @(negedge CLK); Redirect = 1'b0; RST = 1'b0; #1;
      chk("ar_req", 32'(IMemReq), 32'd0);
      chk("ar_addr", IMemAddr, 32'h0);
      chk("ar_valid", 32'(InstrValid), 32'd0);
      chk("ar_instr", Instr, 32'h0);
      chk("ar_pc", InstrPC, 32'h0);
      chk("ar_occ", 32'(Occupancy), 32'd0);
`ifdef FETCH_PERF_COUNT_EN
      chk("ar_redir_cnt", RedirectCount, 32'd0);
      chk("ar_drop_cnt", DropCount, 32'd0);
`endif
      repeat (2) @(negedge CLK);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
